user_lookup: RTL and testbench

- Parametrised memory-lookup controller. Takes a key from the login front end and scans an external synchronous ROM of {level, key} records.
- Ends the scan at a sentinel word or at the last address, then reports whether the key matched and the associated level and address.
- Adds a start/busy/done handshake, early stop on match, configurable ROM latency, and a retry counter with lockout.
- Sits between user login and the game controller. The level feeds a separate 7-segment decoder.

---
 rtl/user_lookup_pkg.sv | 21 ++
 rtl/user_lookup_retry_guard.sv | 40 ++++
 rtl/user_lookup.sv | 131 +++++++++++++
 tb/tb_user_lookup.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/user_lookup_pkg.sv
// Shared types and record-field helpers for the user lookup controller.
package user_lookup_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, CMP, FIN} state_t;

  localparam int unsigned WORD_MAX = 64;
  localparam logic [WORD_MAX-1:0] DEF_SENTINEL = '1;

  function automatic logic [WORD_MAX-1:0] key_of(input logic [WORD_MAX-1:0] word,
                                                 input int unsigned key_w);
    logic [WORD_MAX-1:0] mask;
    mask = (WORD_MAX'(1) << key_w) - WORD_MAX'(1);
    return word & mask;
  endfunction

  function automatic logic [WORD_MAX-1:0] lvl_of(input logic [WORD_MAX-1:0] word,
                                                 input int unsigned key_w);
    return word >> key_w;
  endfunction

endpackage

// File: rtl/user_lookup_retry_guard.sv
// Consecutive-failure counter with lockout; unlock overrides a coincident failure.
module lookup_retry_guard #(
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fin,
  input  logic       i_hit,
  input  logic       i_unlock,
  output logic [3:0] o_fail_cnt,
  output logic       o_locked
);

  logic [3:0] r_cnt;
  logic       r_locked;
  logic [3:0] w_next;

  assign w_next = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_unlock) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_fin) begin
      if (i_hit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_next;
        if (32'(w_next) >= MAX_TRIES) r_locked <= 1'b1;
      end
    end
  end

  assign o_fail_cnt = r_cnt;
  assign o_locked   = r_locked;

endmodule

// File: rtl/user_lookup.sv
// Scans an external synchronous ROM of {level, key} records for a requested key.
module user_lookup
  import user_lookup_pkg::*;
#(
  parameter int unsigned       KEY_W     = 16,
  parameter int unsigned       LVL_W     = 2,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       ROM_LAT   = 1,
  parameter logic [KEY_W-1:0]  SENTINEL  = KEY_W'(DEF_SENTINEL),
  parameter int unsigned       MAX_TRIES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KEY_W-1:0]        key,
  input  logic                    unlock,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [KEY_W+LVL_W-1:0]  rom_data,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [LVL_W-1:0]        level,
  output logic [ADDR_W-1:0]       match_addr,
  output logic [3:0]              fail_cnt,
  output logic                    locked
);

  localparam int unsigned LAT_W = $clog2(ROM_LAT + 1);

  state_t              r_state, w_next;
  logic [KEY_W-1:0]    r_key;
  logic [ADDR_W-1:0]   r_addr;
  logic [LAT_W-1:0]    r_lat;
  logic                r_busy, r_done, r_found;
  logic [LVL_W-1:0]    r_level;
  logic [ADDR_W-1:0]   r_maddr;

  logic [KEY_W-1:0]    w_dkey;
  logic [LVL_W-1:0]    w_dlvl;
  logic                w_sent, w_hit, w_last, w_accept, w_fin, w_locked;

  assign w_dkey   = KEY_W'(key_of(WORD_MAX'(rom_data), KEY_W));
  assign w_dlvl   = LVL_W'(lvl_of(WORD_MAX'(rom_data), KEY_W));
  assign w_sent   = (w_dkey == SENTINEL);
  assign w_hit    = (w_dkey == r_key);
  assign w_last   = &r_addr;
  assign w_accept = start && !w_locked;
  assign w_fin    = (r_state == FIN);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = WAIT;
      WAIT:    if (r_lat == LAT_W'(1)) w_next = CMP;
      CMP:     w_next = (w_sent || w_hit || w_last) ? FIN : WAIT;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Sentinel is tested ahead of match, so a SENTINEL key can never report a hit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_key   <= '0;
      r_addr  <= '0;
      r_lat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_level <= '0;
      r_maddr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_key   <= key;
            r_addr  <= '0;
            r_found <= 1'b0;
            r_level <= '0;
            r_maddr <= '0;
            r_busy  <= 1'b1;
            r_lat   <= LAT_W'(ROM_LAT);
          end
        end
        WAIT: r_lat <= r_lat - LAT_W'(1);
        CMP: begin
          if (w_sent) begin
            r_found <= 1'b0;
          end else if (w_hit) begin
            r_found <= 1'b1;
            r_level <= w_dlvl;
            r_maddr <= r_addr;
          end else if (!w_last) begin
            r_addr <= r_addr + ADDR_W'(1);
            r_lat  <= LAT_W'(ROM_LAT);
          end
        end
        FIN: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  lookup_retry_guard #(.MAX_TRIES(MAX_TRIES)) u_guard (
    .clk        (clk),
    .rst        (rst),
    .i_fin      (w_fin),
    .i_hit      (r_found),
    .i_unlock   (unlock),
    .o_fail_cnt (fail_cnt),
    .o_locked   (w_locked)
  );

  assign rom_addr   = r_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign found      = r_found;
  assign level      = r_level;
  assign match_addr = r_maddr;
  assign locked     = w_locked;

endmodule

// File: tb/tb_user_lookup.sv
// Two user_lookup instances (default, and 8-deep/3-latency) share stimulus; each has its own ROM and model.
module tb_user_lookup;

  localparam int unsigned KW = 16;
  localparam int unsigned AW_A = 8, LAT_A = 1, MT_A = 3;
  localparam int unsigned AW_B = 3, LAT_B = 3, MT_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, unlock;
  logic [KW-1:0] key;

  logic [AW_A-1:0] addr_a, maddr_a;
  logic [AW_B-1:0] addr_b, maddr_b;
  logic [17:0]     data_a, data_b;
  logic            busy_a, done_a, found_a, locked_a;
  logic            busy_b, done_b, found_b, locked_b;
  logic [1:0]      level_a, level_b;
  logic [3:0]      fcnt_a, fcnt_b;

  logic [17:0] rom_a [256];
  logic [17:0] rom_b [8];
  logic [17:0] pa;
  logic [17:0] pb [LAT_B];

  always @(posedge clk) pa <= rom_a[addr_a];
  always @(posedge clk) begin
    pb[0] <= rom_b[addr_b];
    for (int i = 1; i < LAT_B; i++) pb[i] <= pb[i-1];
  end
  assign data_a = pa;
  assign data_b = pb[LAT_B-1];

  user_lookup #(.ADDR_W(AW_A), .ROM_LAT(LAT_A), .MAX_TRIES(MT_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .key(key), .unlock(unlock),
    .rom_addr(addr_a), .rom_data(data_a), .busy(busy_a), .done(done_a),
    .found(found_a), .level(level_a), .match_addr(maddr_a),
    .fail_cnt(fcnt_a), .locked(locked_a));

  user_lookup #(.ADDR_W(AW_B), .ROM_LAT(LAT_B), .MAX_TRIES(MT_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .key(key), .unlock(unlock),
    .rom_addr(addr_b), .rom_data(data_b), .busy(busy_b), .done(done_b),
    .found(found_b), .level(level_b), .match_addr(maddr_b),
    .fail_cnt(fcnt_b), .locked(locked_b));

  logic [31:0] o_addr [2], o_maddr [2], o_lvl [2], o_fcnt [2];
  logic        o_busy [2], o_done [2], o_found [2], o_lock [2];
  assign o_addr[0] = 32'(addr_a);   assign o_addr[1] = 32'(addr_b);
  assign o_maddr[0] = 32'(maddr_a); assign o_maddr[1] = 32'(maddr_b);
  assign o_lvl[0] = 32'(level_a);   assign o_lvl[1] = 32'(level_b);
  assign o_fcnt[0] = 32'(fcnt_a);   assign o_fcnt[1] = 32'(fcnt_b);
  assign o_busy[0] = busy_a;   assign o_busy[1] = busy_b;
  assign o_done[0] = done_a;   assign o_done[1] = done_b;
  assign o_found[0] = found_a; assign o_found[1] = found_b;
  assign o_lock[0] = locked_a; assign o_lock[1] = locked_b;

  int checks = 0;
  int failures = 0;

  int m_cnt [2], m_lvl [2], m_maddr [2], m_raddr [2];
  bit m_lock [2], m_found [2];
  int lat_of [2] = '{LAT_A, LAT_B};
  int mt_of [2]  = '{MT_A, MT_B};
  int dep_of [2] = '{256, 8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [17:0] rom_rd(input int inst, input int a);
    if (inst == 0) return rom_a[a];
    return rom_b[a];
  endfunction

  // Linear search straight from the table rules: first sentinel or first match ends it.
  task automatic scan(input int inst, input logic [15:0] k,
                      output bit hit, output int lvl, output int a, output int probes);
    logic [17:0] w;
    hit = 0; lvl = 0; a = 0; probes = dep_of[inst];
    for (int i = 0; i < dep_of[inst]; i++) begin
      w = rom_rd(inst, i);
      if (w[15:0] == 16'hFFFF) begin probes = i + 1; return; end
      if (w[15:0] == k) begin hit = 1; lvl = int'(w[17:16]); a = i; probes = i + 1; return; end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_lock[i] = 0; m_found[i] = 0; m_lvl[i] = 0; m_maddr[i] = 0; m_raddr[i] = 0;
    end
  endtask

  task automatic chk_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_found%0d", tag, i), 32'(o_found[i]), 32'(m_found[i]));
      chk($sformatf("%s_level%0d", tag, i), o_lvl[i], m_lvl[i]);
      chk($sformatf("%s_maddr%0d", tag, i), o_maddr[i], m_maddr[i]);
      chk($sformatf("%s_raddr%0d", tag, i), o_addr[i], m_raddr[i]);
      chk($sformatf("%s_fcnt%0d", tag, i), o_fcnt[i], m_cnt[i]);
      chk($sformatf("%s_lock%0d", tag, i), 32'(o_lock[i]), 32'(m_lock[i]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(o_busy[i]), 0);
      chk($sformatf("%s_done%0d", tag, i), 32'(o_done[i]), 0);
    end
  endtask

  // u: cycle (relative to the start edge) at which unlock is sampled; 0 = none, <0 = random.
  task automatic lookup(input logic [15:0] k, input int u_in, input bit mid_in);
    bit acc [2]; bit hit [2];
    int lvl [2], a [2], pr [2], d [2], dcyc [2], dcnt [2], bbad [2];
    int last, u; bit mid;
    last = 6;
    for (int i = 0; i < 2; i++) begin
      acc[i] = !m_lock[i]; d[i] = 0; hit[i] = 0; lvl[i] = 0; a[i] = 0; pr[i] = 0;
      if (acc[i]) begin
        scan(i, k, hit[i], lvl[i], a[i], pr[i]);
        d[i] = (lat_of[i] + 1) * pr[i] + 1;
        if (d[i] > last) last = d[i];
      end
      dcyc[i] = -1; dcnt[i] = 0; bbad[i] = 0;
    end
    u = (u_in < 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, last))) : u_in;
    mid = mid_in;
    for (int i = 0; i < 2; i++)
      if (acc[i] ? (d[i] < 6) : (u != 0 && u <= 5)) mid = 0;

    @(negedge clk);
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= last + 3; c++) begin
      unlock = (c == u);
      start  = mid && (c == 5);
      key    = 16'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (o_done[i]) begin dcnt[i]++; if (dcyc[i] < 0) dcyc[i] = c; end
        if (o_busy[i] !== (acc[i] && c < d[i])) bbad[i]++;
      end
    end
    unlock = 1'b0; start = 1'b0;

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("done_cyc%0d", i), dcyc[i], acc[i] ? d[i] : -1);
      chk($sformatf("done_cnt%0d", i), dcnt[i], acc[i] ? 1 : 0);
      chk($sformatf("busy_win%0d", i), bbad[i], 0);
      if (acc[i]) begin
        m_found[i] = hit[i];
        m_lvl[i]   = hit[i] ? lvl[i] : 0;
        m_maddr[i] = hit[i] ? a[i] : 0;
        m_raddr[i] = pr[i] - 1;
        if (u != 0 && u < d[i]) m_cnt[i] = 0;
        m_cnt[i]  = hit[i] ? 0 : ((m_cnt[i] == 15) ? 15 : m_cnt[i] + 1);
        m_lock[i] = (m_cnt[i] >= mt_of[i]);
      end
      if (u != 0 && (!acc[i] || u >= d[i])) begin m_cnt[i] = 0; m_lock[i] = 0; end
    end
    chk_state("post");
  endtask

  task automatic reset_mid(input logic [15:0] k);
    int dn;
    @(negedge clk);
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    chk_state("rstmid");
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a || done_b || busy_a || busy_b) dn++;
    end
    chk("rstmid_nodone", dn, 0);
  endtask

  task automatic fill_random();
    int sa, sb;
    sa = $urandom_range(0, 300);
    sb = $urandom_range(0, 10);
    for (int i = 0; i < 256; i++)
      rom_a[i] = (i == sa) ? {2'($urandom), 16'hFFFF} : {2'($urandom), 16'($urandom_range(0, 31))};
    for (int i = 0; i < 8; i++)
      rom_b[i] = (i == sb) ? {2'($urandom), 16'hFFFF} : {2'($urandom), 16'($urandom_range(0, 15))};
  endtask

  initial begin
    logic [15:0] k;
    rst = 1'b0; start = 1'b0; unlock = 1'b0; key = '0;
    for (int i = 0; i < 256; i++) rom_a[i] = '0;
    rom_a[0] = {2'd1, 16'h1234};
    rom_a[1] = {2'd2, 16'h1235};
    rom_a[2] = {2'd0, 16'hFFFF};
    for (int i = 0; i < 8; i++) rom_b[i] = {2'(i), 16'(i + 1)};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset");
    @(negedge clk);
    rst = 1'b1;

    lookup(16'h1235, 0, 0);
    lookup(16'hABCD, 0, 0);
    lookup(16'hABCD, 0, 0);
    lookup(16'hABCD, 0, 0);
    lookup(16'hABCD, 0, 0);
    lookup(16'hABCD, 1, 0);
    lookup(16'hABCD, 0, 0);
    lookup(16'hABCD, 0, 0);
    lookup(16'hABCD, 7, 0);
    lookup(16'h1234, 0, 0);
    lookup(16'h0003, 0, 1);
    lookup(16'h0008, 0, 0);
    lookup(16'h0009, 0, 0);
    reset_mid(16'h1234);
    lookup(16'hFFFF, 0, 0);

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) fill_random();
      case ($urandom_range(0, 3))
        0: k = 16'hFFFF;
        1: k = 16'($urandom);
        default: k = 16'($urandom_range(0, 31));
      endcase
      lookup(k, -1, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
